alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Register-file-plus-operand-latch stage that sits directly upstream of the 32-bit ALU.
- Reads rs/rt from a 32x32 register file and selects register or extended immediate for operand B.
- Registers a, b and the 3-bit ALU control line into an output slot, with a valid/ready handshake and flush.
- Keeps held operands coherent with write-back while the downstream ALU stalls.

Parameters:
- DATA_W, 32, register/operand width
- ADDR_W, 5, register index width (2**ADDR_W registers)
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept this cycle
- rs_addr  in  ADDR_W  source register index for operand A
- rt_addr  in  ADDR_W  source register index for operand B / store data
- imm16  in  16  instruction immediate
- alu_src  in  1  1 = B takes extended immediate, 0 = B takes rt
- ext_sign  in  1  1 = sign-extend imm16, 0 = zero-extend
- gin_in  in  3  ALU control line (010 add, 110 sub, 111 slt, 000 and, 001 or)
- flush  in  1  kill held and incoming operation
- wr_en  in  1  write-back enable
- wr_addr  in  ADDR_W  write-back index
- wr_data  in  DATA_W  write-back data
- out_valid  out  1  alu_a/alu_b/alu_gin hold a valid operation
- out_ready  in  1  ALU stage consumes this cycle
- alu_a  out  DATA_W  operand A
- alu_b  out  DATA_W  operand B
- alu_gin  out  3  registered ALU control line
- rt_data  out  DATA_W  registered rt value (store data), independent of alu_src
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid & !out_ready

Behaviour:
- Reset (synchronous): all 32 registers = 0; out_valid = 0; alu_a = alu_b = rt_data = 0; alu_gin = 3'b000; stall_cnt = 0; held indices = 0.
- in_ready = !flush && (!out_valid || out_ready). This is combinational.
- Register 0: reads always return 0, and writes to index 0 are dropped.
- Write-back: when wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data at the clock edge.
- Read bypass: in the same cycle, if wr_en=1, wr_addr!=0 and wr_addr equals rs_addr (or rt_addr), the read returns wr_data instead of the stale array value.
- Immediate extension: ext_sign=1 gives {{16{imm16[15]}},imm16}; ext_sign=0 gives {16'b0,imm16}.
- Capture: when in_valid && in_ready, on the clock edge:
  - alu_a = bypassed rs value
  - alu_b = alu_src ? ext_imm : bypassed rt value
  - rt_data = bypassed rt value
  - alu_gin = gin_in
  - out_valid = 1
  - rs_addr, rt_addr and alu_src are stored as held_rs, held_rt, held_src
- Latency: one cycle from accepted input to out_valid.
- Drain: if out_valid && out_ready and no new capture occurs, out_valid = 0 next cycle. Data outputs keep their last values.
- Back-to-back: accept and drain in the same cycle are allowed, giving one operation per cycle throughput.
- Held-operand coherence: while out_valid && !out_ready, a write-back with wr_addr!=0 updates the held operands at the edge:
  - if wr_addr==held_rs, alu_a = wr_data
  - if wr_addr==held_rt, rt_data = wr_data, and also alu_b = wr_data when held_src=0
  - the register array is written in the same edge
- Flush:
  - out_valid = 0 next cycle; no capture that cycle because in_ready=0.
  - Flush does not block write-back.
  - Flush overrides out_ready.
- stall_cnt increments each cycle with out_valid && !out_ready and saturates at all-ones. It is cleared only by reset.
- Reset asserted mid-operation: reset wins over capture, flush and write-back in that cycle.
- alu_gin is passed through unchanged. Undefined codes are not checked here.

Test Plan:
- Reset, then write r5=0x0000_0010 and r6=0xFFFF_FFF0; issue rs=5, rt=6, alu_src=0, gin=010 -> one cycle later out_valid=1, alu_a=0x10, alu_b=0xFFFFFFF0, alu_gin=010.
- Bypass: wr_en writes r7=0x1234_5678 in the same cycle that an op with rs=7 is accepted -> alu_a=0x12345678. Write r0=0xDEAD then read rs=0 -> alu_a=0.
- Immediate: imm16=0x8001 with ext_sign=1 -> alu_b=0xFFFF8001; with ext_sign=0 -> 0x00008001. In both cases rt_data equals reg[rt].
- Stall: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; write r6=0x55 during the stall with held_rt=6 and alu_src=0 -> alu_b=0x55, stall_cnt=3; release out_ready -> drains, and next op accepted the same cycle.
- Flush during stall with in_valid=1 -> out_valid=0 next cycle, no capture; a concurrent write-back still lands in the register file.
- Assert reset while out_valid=1 and wr_en=1 -> next cycle out_valid=0, all registers read 0, stall_cnt=0.

Source files
------------

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : Register file plus operand latch feeding the 32-bit ALU.
//               Reads rs/rt with write-back bypass, selects register or
//               extended immediate for operand B, and holds the operation in
//               a valid/ready output slot that stays coherent with
//               write-back while the ALU stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [15:0]       imm16,
  input  logic              alu_src,
  input  logic              ext_sign,
  input  logic [2:0]        gin_in,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_gin,
  output logic [DATA_W-1:0] rt_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int c_NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [c_NREGS];

  logic              r_out_valid;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [DATA_W-1:0] r_rt_data;
  logic [2:0]        r_alu_gin;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [ADDR_W-1:0] r_held_rs;
  logic [ADDR_W-1:0] r_held_rt;
  logic              r_held_src;

  logic              w_wb;
  logic              w_in_ready;
  logic              w_capture;
  logic              w_stalled;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic [DATA_W-1:0] w_ext_imm;

  // Write-back qualification, read bypass, immediate extension and handshake
  always_comb begin
    w_wb = wr_en && (wr_addr != '0);

    if (rs_addr == '0)
      w_rs_val = '0;
    else if (w_wb && (wr_addr == rs_addr))
      w_rs_val = wr_data;
    else
      w_rs_val = r_regs[rs_addr];

    if (rt_addr == '0)
      w_rt_val = '0;
    else if (w_wb && (wr_addr == rt_addr))
      w_rt_val = wr_data;
    else
      w_rt_val = r_regs[rt_addr];

    if (ext_sign)
      w_ext_imm = {{(DATA_W-16){imm16[15]}}, imm16};
    else
      w_ext_imm = {{(DATA_W-16){1'b0}}, imm16};

    w_in_ready = !flush && (!r_out_valid || out_ready);
    w_capture  = in_valid && w_in_ready;
    w_stalled  = r_out_valid && !out_ready;
  end

  // Register array: cleared on reset, index 0 never written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_NREGS; i++)
        r_regs[i] <= '0;
    end else if (w_wb) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Output slot: capture, drain/flush, and held-operand write-back coherence
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_rt_data   <= '0;
      r_alu_gin   <= 3'b000;
      r_held_rs   <= '0;
      r_held_rt   <= '0;
      r_held_src  <= 1'b0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_alu_a     <= w_rs_val;
      r_alu_b     <= alu_src ? w_ext_imm : w_rt_val;
      r_rt_data   <= w_rt_val;
      r_alu_gin   <= gin_in;
      r_held_rs   <= rs_addr;
      r_held_rt   <= rt_addr;
      r_held_src  <= alu_src;
    end else begin
      // Flush overrides a stall; a consumed operation simply drains
      if (flush || out_ready)
        r_out_valid <= 1'b0;
      // A stalled operation tracks write-backs to the registers it read
      if (w_stalled && w_wb) begin
        if (wr_addr == r_held_rs)
          r_alu_a <= wr_data;
        if (wr_addr == r_held_rt) begin
          r_rt_data <= wr_data;
          if (!r_held_src)
            r_alu_b <= wr_data;
        end
      end
    end
  end

  // Saturating count of stalled cycles, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset)
      r_stall_cnt <= '0;
    else if (w_stalled && (r_stall_cnt != {CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign rt_data   = r_rt_data;
  assign alu_gin   = r_alu_gin;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Directed, table-driven bench for alu_operand_stage, with
//               hand-written stall, flush and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [15:0] imm16;
  logic        alu_src;
  logic        ext_sign;
  logic [2:0]  gin_in;
  logic        flush;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_gin;
  logic [31:0] rt_data;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  alu_operand_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .imm16(imm16), .alu_src(alu_src),
    .ext_sign(ext_sign), .gin_in(gin_in), .flush(flush), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .out_valid(out_valid),
    .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_gin(alu_gin),
    .rt_data(rt_data), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        src;
    logic        ext;
    logic [2:0]  gin;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_rt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_op(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm,
                        input logic src, input logic ext, input logic [2:0] gin);
    in_valid = 1'b1;
    rs_addr  = rs;
    rt_addr  = rt;
    imm16    = imm;
    alu_src  = src;
    ext_sign = ext;
    gin_in   = gin;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
  endtask

  // advance one clock and sample just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // vector table: each entry is accepted with out_ready=1 (back-to-back)
    vecs[0] = '{5'd5, 5'd6, 16'h0000, 1'b0, 1'b0, 3'b010, 1'b0, 5'd0, 32'h0,
                32'h0000_0010, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
    vecs[1] = '{5'd7, 5'd5, 16'h0000, 1'b0, 1'b0, 3'b110, 1'b1, 5'd7, 32'h1234_5678,
                32'h1234_5678, 32'h0000_0010, 32'h0000_0010};
    vecs[2] = '{5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 3'b111, 1'b1, 5'd0, 32'h0000_DEAD,
                32'h0, 32'h0, 32'h0};
    vecs[3] = '{5'd6, 5'd5, 16'h8001, 1'b1, 1'b1, 3'b000, 1'b0, 5'd0, 32'h0,
                32'hFFFF_FFF0, 32'hFFFF_8001, 32'h0000_0010};
    vecs[4] = '{5'd6, 5'd5, 16'h8001, 1'b1, 1'b0, 3'b001, 1'b0, 5'd0, 32'h0,
                32'hFFFF_FFF0, 32'h0000_8001, 32'h0000_0010};
    vecs[5] = '{5'd7, 5'd7, 16'h0000, 1'b0, 1'b0, 3'b010, 1'b0, 5'd0, 32'h0,
                32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
    vecs[6] = '{5'd5, 5'd8, 16'h0000, 1'b0, 1'b0, 3'b110, 1'b1, 5'd8, 32'hCAFE_0001,
                32'h0000_0010, 32'hCAFE_0001, 32'hCAFE_0001};
    vecs[7] = '{5'd0, 5'd8, 16'h7FFF, 1'b1, 1'b1, 3'b111, 1'b0, 5'd0, 32'h0,
                32'h0, 32'h0000_7FFF, 32'hCAFE_0001};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    rs_addr = '0; rt_addr = '0; imm16 = '0; alu_src = 1'b0; ext_sign = 1'b0; gin_in = '0;
    set_wb(1'b0, 5'd0, 32'h0);
    step(); step();
    reset = 1'b0;

    // reset state
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_rt_data", rt_data, 32'h0);
    chk("rst_alu_gin", {29'b0, alu_gin}, 32'h0);
    chk("rst_stall_cnt", {16'b0, stall_cnt}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

    // preload r5, r6
    set_wb(1'b1, 5'd5, 32'h0000_0010); step();
    set_wb(1'b1, 5'd6, 32'hFFFF_FFF0); step();
    set_wb(1'b0, 5'd0, 32'h0);

    for (int i = 0; i < 8; i++) begin
      set_op(vecs[i].rs, vecs[i].rt, vecs[i].imm, vecs[i].src, vecs[i].ext, vecs[i].gin);
      set_wb(vecs[i].we, vecs[i].wa, vecs[i].wd);
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'h1);
      step();
      chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, 32'h1);
      chk($sformatf("v%0d_alu_a", i), alu_a, vecs[i].exp_a);
      chk($sformatf("v%0d_alu_b", i), alu_b, vecs[i].exp_b);
      chk($sformatf("v%0d_rt_data", i), rt_data, vecs[i].exp_rt);
      chk($sformatf("v%0d_alu_gin", i), {29'b0, alu_gin}, {29'b0, vecs[i].gin});
    end
    set_wb(1'b0, 5'd0, 32'h0);

    // drain with no new input
    in_valid = 1'b0;
    step();
    chk("drain_out_valid", {31'b0, out_valid}, 32'h0);
    chk("drain_alu_a_kept", alu_a, 32'h0);
    chk("drain_alu_b_kept", alu_b, 32'h0000_7FFF);

    // stall: capture rs5/rt6, then hold out_ready low for 3 cycles
    set_op(5'd5, 5'd6, 16'h0000, 1'b0, 1'b0, 3'b010);
    step();
    out_ready = 1'b0;
    set_op(5'd7, 5'd7, 16'h0000, 1'b0, 1'b0, 3'b110);
    #1;
    chk("stall_in_ready", {31'b0, in_ready}, 32'h0);
    step();
    set_wb(1'b1, 5'd6, 32'h0000_0055);
    step();
    set_wb(1'b0, 5'd0, 32'h0);
    step();
    chk("stall_out_valid", {31'b0, out_valid}, 32'h1);
    chk("stall_alu_a", alu_a, 32'h0000_0010);
    chk("stall_alu_b_coherent", alu_b, 32'h0000_0055);
    chk("stall_rt_data_coherent", rt_data, 32'h0000_0055);
    chk("stall_alu_gin", {29'b0, alu_gin}, 32'h2);
    chk("stall_cnt_3", {16'b0, stall_cnt}, 32'd3);

    // release: drain and accept in the same cycle; r6 array must hold 0x55
    out_ready = 1'b1;
    set_op(5'd6, 5'd7, 16'h0000, 1'b0, 1'b0, 3'b110);
    #1;
    chk("release_in_ready", {31'b0, in_ready}, 32'h1);
    step();
    chk("release_out_valid", {31'b0, out_valid}, 32'h1);
    chk("release_alu_a", alu_a, 32'h0000_0055);
    chk("release_alu_b", alu_b, 32'h1234_5678);
    chk("release_stall_cnt", {16'b0, stall_cnt}, 32'd3);

    // flush during stall with in_valid=1 and a concurrent write-back
    out_ready = 1'b0;
    flush = 1'b1;
    set_op(5'd5, 5'd5, 16'h0000, 1'b0, 1'b0, 3'b001);
    set_wb(1'b1, 5'd9, 32'h0000_0099);
    #1;
    chk("flush_in_ready", {31'b0, in_ready}, 32'h0);
    step();
    flush = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);
    chk("flush_out_valid", {31'b0, out_valid}, 32'h0);
    chk("flush_no_capture_a", alu_a, 32'h0000_0055);
    chk("flush_no_capture_gin", {29'b0, alu_gin}, 32'h6);
    chk("flush_stall_cnt", {16'b0, stall_cnt}, 32'd4);
    out_ready = 1'b1;
    set_op(5'd9, 5'd0, 16'h0000, 1'b0, 1'b0, 3'b010);
    step();
    chk("flush_wb_landed", alu_a, 32'h0000_0099);

    // reset while out_valid=1 with a write-back and an incoming op
    out_ready = 1'b0;
    reset = 1'b1;
    set_op(5'd5, 5'd6, 16'h0000, 1'b0, 1'b0, 3'b010);
    set_wb(1'b1, 5'd10, 32'h0000_00AA);
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_stall_cnt", {16'b0, stall_cnt}, 32'h0);
    chk("midrst_alu_a", alu_a, 32'h0);
    out_ready = 1'b1;
    set_op(5'd5, 5'd6, 16'h0000, 1'b0, 1'b0, 3'b010);
    step();
    chk("midrst_r5", alu_a, 32'h0);
    chk("midrst_r6", alu_b, 32'h0);
    set_op(5'd9, 5'd10, 16'h0000, 1'b0, 1'b0, 3'b010);
    step();
    chk("midrst_r9", alu_a, 32'h0);
    chk("midrst_r10", alu_b, 32'h0);
    chk("midrst_read_valid", {31'b0, out_valid}, 32'h1);
    in_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
